// File: rtl/thread_fetch_sched.sv
// Fetch-side thread scheduler: keeps a PC and READY/WAIT state per hardware thread,
// picks one eligible thread per cycle round-robin, and reacts to issue/miss/branch/refill events.
module thread_fetch_sched #(
    parameter int unsigned N_THREADS   = 4,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned INSTR_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PC_W-1:0]              boot_pc_i,
    output logic                         fetch_valid_o,
    output logic [$clog2(N_THREADS)-1:0] fetch_thread_o,
    output logic [PC_W-1:0]              fetch_pc_o,
    input  logic                         fb_valid_i,
    input  logic [$clog2(N_THREADS)-1:0] fb_thread_i,
    input  logic                         fb_issued_i,
    input  logic                         fb_miss_i,
    input  logic                         refill_done_i,
    input  logic [$clog2(N_THREADS)-1:0] refill_thread_i,
    input  logic                         br_taken_i,
    input  logic [$clog2(N_THREADS)-1:0] br_thread_i,
    input  logic [PC_W-1:0]              br_target_i,
    output logic [N_THREADS-1:0]         thread_waiting_o
);

    localparam int unsigned TW = $clog2(N_THREADS);

    logic [PC_W-1:0]      pc_q [N_THREADS];
    logic [PC_W-1:0]      pc_d [N_THREADS];
    logic [N_THREADS-1:0] wait_q, wait_d;
    logic [N_THREADS-1:0] outst_q, outst_d;
    logic [N_THREADS-1:0] elig;
    logic [TW-1:0]        rr_q, rr_d;
    logic [TW-1:0]        sel, idx;
    logic                 sel_vld;
    logic                 fb_hit;

    logic                 fetch_valid_q, fetch_valid_d;
    logic [TW-1:0]        fetch_thread_q, fetch_thread_d;
    logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;

    // A thread with an event landing this cycle is held back so it never fetches a stale PC.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            elig[i] = !wait_q[i] && !outst_q[i]
                      && !(br_taken_i && (br_thread_i == TW'(i)))
                      && !(fb_valid_i && (fb_thread_i == TW'(i)));
        end
    end

    // Scan rr_q+1 .. rr_q+N; the TW-bit sum wraps naturally since N_THREADS is a power of 2.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_THREADS; k++) begin
            idx = rr_q + TW'(k);
            if (!sel_vld && elig[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    assign fb_hit = fb_valid_i && outst_q[fb_thread_i];

    always_comb begin
        rr_d           = sel_vld ? sel : rr_q;
        fetch_valid_d  = sel_vld;
        fetch_thread_d = sel;
        fetch_pc_d     = pc_q[sel];
        wait_d         = wait_q;
        outst_d        = outst_q;
        for (int i = 0; i < N_THREADS; i++) begin
            pc_d[i] = pc_q[i];
            if (refill_done_i && (refill_thread_i == TW'(i))) begin
                wait_d[i] = 1'b0;
            end
            // Miss is applied after refill so a same-cycle miss leaves the thread parked.
            if (fb_hit && (fb_thread_i == TW'(i))) begin
                outst_d[i] = 1'b0;
                if (fb_miss_i) begin
                    wait_d[i] = 1'b1;
                end else if (fb_issued_i) begin
                    pc_d[i] = pc_q[i] + PC_W'(INSTR_BYTES);
                end
            end
            if (br_taken_i && (br_thread_i == TW'(i))) begin
                pc_d[i] = br_target_i;
            end
            if (sel_vld && (sel == TW'(i))) begin
                outst_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                pc_q[i] <= boot_pc_i;
            end
            wait_q         <= '0;
            outst_q        <= '0;
            rr_q           <= TW'(N_THREADS - 1);
            fetch_valid_q  <= 1'b0;
            fetch_thread_q <= '0;
            fetch_pc_q     <= '0;
        end else begin
            for (int i = 0; i < N_THREADS; i++) begin
                pc_q[i] <= pc_d[i];
            end
            wait_q         <= wait_d;
            outst_q        <= outst_d;
            rr_q           <= rr_d;
            fetch_valid_q  <= fetch_valid_d;
            fetch_thread_q <= fetch_thread_d;
            fetch_pc_q     <= fetch_pc_d;
        end
    end

    assign fetch_valid_o    = fetch_valid_q;
    assign fetch_thread_o   = fetch_thread_q;
    assign fetch_pc_o       = fetch_pc_q;
    assign thread_waiting_o = wait_q;

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Randomized and directed bench for thread_fetch_sched against a per-thread behavioural model.
module tb_thread_fetch_sched;

    logic        clk;
    logic        rst;
    logic [31:0] boot_pc;
    logic        fetch_valid;
    logic [1:0]  fetch_thread;
    logic [31:0] fetch_pc;
    logic        fb_valid;
    logic [1:0]  fb_thread;
    logic        fb_issued;
    logic        fb_miss;
    logic        refill_done;
    logic [1:0]  refill_thread;
    logic        br_taken;
    logic [1:0]  br_thread;
    logic [31:0] br_target;
    logic [3:0]  thread_waiting;

    int checks = 0;
    int errors = 0;

    thread_fetch_sched #(
        .N_THREADS  (4),
        .PC_W       (32),
        .INSTR_BYTES(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .boot_pc_i       (boot_pc),
        .fetch_valid_o   (fetch_valid),
        .fetch_thread_o  (fetch_thread),
        .fetch_pc_o      (fetch_pc),
        .fb_valid_i      (fb_valid),
        .fb_thread_i     (fb_thread),
        .fb_issued_i     (fb_issued),
        .fb_miss_i       (fb_miss),
        .refill_done_i   (refill_done),
        .refill_thread_i (refill_thread),
        .br_taken_i      (br_taken),
        .br_thread_i     (br_thread),
        .br_target_i     (br_target),
        .thread_waiting_o(thread_waiting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-thread PC, parked flag, in-flight flag, last-granted thread.
    bit [31:0] m_pc   [4];
    bit        m_wait [4];
    bit        m_out  [4];
    int        m_rr;
    logic        e_valid;
    logic [1:0]  e_thr;
    logic [31:0] e_pc;
    logic [3:0]  e_wait;

    // Environment policy for the feedback of each thread's fetch.
    bit [3:0] miss_mask  = '0;
    bit [3:0] stall_mask = '0;
    bit       spur_en    = 1'b0;

    task automatic model_step();
        int pick;
        int t;
        pick = -1;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pc[i] = boot_pc; m_wait[i] = 0; m_out[i] = 0;
            end
            m_rr = 3; e_valid = 0; e_thr = 0; e_pc = 0; e_wait = 0;
            return;
        end
        for (int k = 1; k <= 4; k++) begin
            t = (m_rr + k) % 4;
            if (pick < 0 && !m_wait[t] && !m_out[t] && !(br_taken && int'(br_thread) == t)
                && !(fb_valid && int'(fb_thread) == t))
                pick = t;
        end
        e_valid = (pick >= 0);
        if (pick >= 0) begin
            e_thr = 2'(pick);
            e_pc  = m_pc[pick];
        end
        if (refill_done) m_wait[refill_thread] = 0;
        if (fb_valid && m_out[fb_thread]) begin
            m_out[fb_thread] = 0;
            if (fb_miss) m_wait[fb_thread] = 1;
            else if (fb_issued) m_pc[fb_thread] = m_pc[fb_thread] + 32'd4;
        end
        if (br_taken) m_pc[br_thread] = br_target;
        if (pick >= 0) begin
            m_out[pick] = 1;
            m_rr = pick;
        end
        e_wait = {m_wait[3], m_wait[2], m_wait[1], m_wait[0]};
    endtask

    // Drive feedback for last cycle's expected fetch, advance model and clock, sample at +1.
    task automatic run_cycle();
        fb_valid  = e_valid;
        fb_thread = e_thr;
        fb_miss   = e_valid && miss_mask[e_thr];
        fb_issued = e_valid && !stall_mask[e_thr];
        if (!e_valid && spur_en && $urandom_range(0, 3) == 0) begin
            fb_valid  = 1'b1;
            fb_thread = 2'($urandom_range(0, 3));
            fb_issued = 1'($urandom);
            fb_miss   = 1'($urandom);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        refill_done = 0; refill_thread = 0; br_taken = 0; br_thread = 0; br_target = 0;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        boot_pc = boot; rst = 1'b1;
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int          seq [5] = '{0, 1, 2, 3, 0};
        logic [31:0] pcs [5] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
        clear_events();
        boot_pc = 32'h1000; rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            run_cycle();
            checks++;
            if ({fetch_valid, fetch_thread, fetch_pc, thread_waiting} !== 39'd0)
                begin errors++; $display("FAIL reset_outputs: got v=%b t=%0d pc=%h w=%b, want all zero",
                    fetch_valid, fetch_thread, fetch_pc, thread_waiting); end
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            checks++;
            if (fetch_valid !== 1'b1 || int'(fetch_thread) != seq[c] || fetch_pc !== pcs[c])
                begin errors++; $display("FAIL reset_seq[%0d]: got v=%b t=%0d pc=%h, want v=1 t=%0d pc=%h",
                    c, fetch_valid, fetch_thread, fetch_pc, seq[c], pcs[c]); end
        end
    endtask

    task automatic test_replay();
        int          st = 0;
        logic [31:0] spc = 0;
        for (int c = 0; c < 20 && st != 2; c++) begin
            bit stalling;
            stalling = (st == 0 && e_valid && e_thr == 2'd1);
            if (stalling) begin stall_mask = 4'b0010; spc = e_pc; end
            run_cycle();
            stall_mask = 0;
            checks++;
            if (fetch_valid !== e_valid || thread_waiting !== e_wait
                || (e_valid && (fetch_thread !== e_thr || fetch_pc !== e_pc)))
                begin errors++; $display("FAIL replay_model: got v=%b t=%0d pc=%h w=%b, want v=%b t=%0d pc=%h w=%b",
                    fetch_valid, fetch_thread, fetch_pc, thread_waiting, e_valid, e_thr, e_pc, e_wait); end
            if (stalling) st = 1;
            else if (st == 1 && e_valid && e_thr == 2'd1) begin
                checks++;
                if (fetch_pc !== spc)
                    begin errors++; $display("FAIL replay_pc: got %h, want %h", fetch_pc, spc); end
                st = 2;
            end
        end
        if (st != 2) begin checks++; errors++; $display("FAIL replay_timeout: state %0d, want 2", st); end
    endtask

    task automatic test_miss();
        int          st = 0;
        logic [31:0] mpc = 0;
        for (int c = 0; c < 20 && st == 0; c++) begin
            if (e_valid && e_thr == 2'd2) begin
                miss_mask = 4'b0100; mpc = e_pc; st = 1;
            end
            run_cycle();
        end
        miss_mask = 0;
        checks++;
        if (thread_waiting !== 4'b0100)
            begin errors++; $display("FAIL miss_park: got w=%b, want 0100", thread_waiting); end
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            checks++;
            if (fetch_valid !== e_valid || thread_waiting !== e_wait
                || (e_valid && (fetch_thread !== e_thr || fetch_pc !== e_pc))
                || (fetch_valid && fetch_thread == 2'd2))
                begin errors++; $display("FAIL miss_skip: got v=%b t=%0d pc=%h w=%b, want v=%b t=%0d pc=%h w=%b",
                    fetch_valid, fetch_thread, fetch_pc, thread_waiting, e_valid, e_thr, e_pc, e_wait); end
        end
        refill_done = 1; refill_thread = 2;
        run_cycle();
        clear_events();
        st = 0;
        for (int c = 0; c < 10 && st == 0; c++) begin
            run_cycle();
            if (e_valid && e_thr == 2'd2) begin
                st = 1;
                checks++;
                if (fetch_valid !== 1'b1 || fetch_thread !== 2'd2 || fetch_pc !== mpc
                    || thread_waiting !== 4'b0000)
                    begin errors++; $display("FAIL miss_unpark: got v=%b t=%0d pc=%h w=%b, want v=1 t=2 pc=%h w=0000",
                        fetch_valid, fetch_thread, fetch_pc, thread_waiting, mpc); end
            end
        end
        if (st == 0) begin checks++; errors++; $display("FAIL unpark_timeout: got none, want thread 2 fetch"); end
    endtask

    task automatic test_branch_collision();
        int st = 0;
        do_reset(32'h1000);
        run_cycle();
        // Thread 0 was fetched; its issue feedback now coincides with a taken branch.
        br_taken = 1; br_thread = 0; br_target = 32'h2000;
        run_cycle();
        clear_events();
        for (int c = 0; c < 10 && st == 0; c++) begin
            run_cycle();
            if (e_valid && e_thr == 2'd0) begin
                st = 1;
                checks++;
                if (fetch_valid !== 1'b1 || fetch_thread !== 2'd0 || fetch_pc !== 32'h2000)
                    begin errors++; $display("FAIL branch_pc: got v=%b t=%0d pc=%h, want v=1 t=0 pc=00002000",
                        fetch_valid, fetch_thread, fetch_pc); end
            end
        end
        if (st == 0) begin checks++; errors++; $display("FAIL branch_timeout: got none, want thread 0 fetch"); end
    endtask

    task automatic test_single();
        bit prev = 0;
        int nvalid = 0;
        do_reset(32'h1000);
        miss_mask = 4'b1110;
        for (int c = 0; c < 12; c++) run_cycle();
        checks++;
        if (thread_waiting !== 4'b1110)
            begin errors++; $display("FAIL single_park: got w=%b, want 1110", thread_waiting); end
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            checks++;
            if ((prev && fetch_valid) || (fetch_valid && fetch_thread !== 2'd0) || fetch_valid !== e_valid
                || (e_valid && fetch_pc !== e_pc))
                begin errors++; $display("FAIL single_rate: got v=%b prev=%b t=%0d pc=%h, want v=%b t=0 pc=%h",
                    fetch_valid, prev, fetch_thread, fetch_pc, e_valid, e_pc); end
            prev = fetch_valid;
            if (fetch_valid) nvalid++;
        end
        checks++;
        if (nvalid < 3) begin errors++; $display("FAIL single_count: got %0d fetches, want >= 3", nvalid); end
        miss_mask = 4'b1111;
        for (int c = 0; c < 6; c++) run_cycle();
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            checks++;
            if (fetch_valid !== 1'b0 || thread_waiting !== 4'b1111)
                begin errors++; $display("FAIL all_wait: got v=%b w=%b, want v=0 w=1111",
                    fetch_valid, thread_waiting); end
        end
        miss_mask = 0;
    endtask

    task automatic test_midreset();
        do_reset(32'h1000);
        miss_mask = 4'b1000;
        for (int c = 0; c < 12; c++) run_cycle();
        miss_mask = 0;
        checks++;
        if (thread_waiting !== 4'b1000)
            begin errors++; $display("FAIL mid_prepark: got w=%b, want 1000", thread_waiting); end
        rst = 1; boot_pc = 32'h8000;
        br_taken = 1; br_thread = 0; br_target = 32'hdead_0000;
        refill_done = 1; refill_thread = 3;
        run_cycle();
        clear_events();
        rst = 0;
        checks++;
        if ({fetch_valid, fetch_thread, fetch_pc, thread_waiting} !== 39'd0)
            begin errors++; $display("FAIL mid_reset: got v=%b t=%0d pc=%h w=%b, want all zero",
                fetch_valid, fetch_thread, fetch_pc, thread_waiting); end
        run_cycle();
        checks++;
        if (fetch_valid !== 1'b1 || fetch_thread !== 2'd0 || fetch_pc !== 32'h8000)
            begin errors++; $display("FAIL mid_first: got v=%b t=%0d pc=%h, want v=1 t=0 pc=00008000",
                fetch_valid, fetch_thread, fetch_pc); end
    endtask

    task automatic test_random();
        do_reset(32'hffff_fff0);
        spur_en = 1;
        for (int c = 0; c < 400; c++) begin
            miss_mask     = 4'($urandom & $urandom & $urandom);
            stall_mask    = 4'($urandom);
            refill_done   = ($urandom_range(0, 2) == 0);
            refill_thread = 2'($urandom_range(0, 3));
            br_taken      = ($urandom_range(0, 4) == 0);
            br_thread     = 2'($urandom_range(0, 3));
            br_target     = $urandom & 32'hffff_fffc;
            run_cycle();
            checks++;
            if (fetch_valid !== e_valid || thread_waiting !== e_wait
                || (e_valid && (fetch_thread !== e_thr || fetch_pc !== e_pc)))
                begin errors++; $display("FAIL random[%0d]: got v=%b t=%0d pc=%h w=%b, want v=%b t=%0d pc=%h w=%b",
                    c, fetch_valid, fetch_thread, fetch_pc, thread_waiting, e_valid, e_thr, e_pc, e_wait); end
        end
        spur_en = 0; miss_mask = 0; stall_mask = 0;
        clear_events();
    endtask

    initial begin
        rst = 1; boot_pc = 0; fb_valid = 0; fb_thread = 0; fb_issued = 0; fb_miss = 0;
        e_valid = 0; e_thr = 0; e_pc = 0; e_wait = 0; m_rr = 3;
        clear_events();
        test_reset();
        test_replay();
        test_miss();
        test_branch_collision();
        test_single();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thread_fetch_sched.md
Name: thread_fetch_sched

Overview:
Fetch-side thread scheduler: the consumer of the hazard unit's per-instruction valid verdict.
- Holds a PC and a READY/WAIT state per hardware thread.
- Picks one eligible thread per cycle round-robin and presents its PC to the ITLB/icache.
- Uses next-cycle issue feedback (valid / replay / miss) plus branch and refill events to advance, replay or park each thread.

Parameters:
N_THREADS, 4, number of hardware threads (power of 2, >=2)
PC_W, 32, program counter width
INSTR_BYTES, 4, PC increment on successful issue

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
boot_pc  in  PC_W  PC loaded into every thread at reset
fetch_valid  out  1  fetch_pc/fetch_thread valid this cycle
fetch_thread  out  log2(N_THREADS)  thread being fetched
fetch_pc  out  PC_W  fetch address
fb_valid  in  1  feedback present for the previous cycle's fetch
fb_thread  in  log2(N_THREADS)  thread the feedback refers to
fb_issued  in  1  instruction accepted (hazard unit's isvalid)
fb_miss  in  1  ITLB or icache miss on that fetch
refill_done  in  1  miss serviced
refill_thread  in  log2(N_THREADS)  thread whose miss is serviced
br_taken  in  1  taken-branch redirect
br_thread  in  log2(N_THREADS)  redirected thread
br_target  in  PC_W  redirect target
thread_waiting  out  N_THREADS  bit i = thread i in WAIT

Behaviour:
- Reset (sync, rst=1 at posedge):
  - all pc[i]=boot_pc; all threads READY; outstanding mask=0; rr_ptr=N_THREADS-1.
  - Outputs: fetch_valid=0, fetch_thread=0, fetch_pc=0, thread_waiting=0.
  - rst overrides every other input in that cycle.
- Fetch outputs are registered.
  - Eligible(i) = READY(i) && !outstanding(i) && !(br_taken && br_thread==i) && !(fb_valid && fb_thread==i) in the selecting cycle.
  - Select the first eligible thread after rr_ptr in modular order, i.e. rr_ptr+1 .. rr_ptr+N wrapping. The selection is registered.
  - If a thread is selected: fetch_valid=1, fetch_thread=sel, fetch_pc=pc[sel], rr_ptr<=sel, outstanding[sel]<=1.
  - If none is eligible: fetch_valid=0 and rr_ptr is unchanged.
- Feedback: exactly one cycle after fetch_valid=1 for thread T, the environment drives fb_valid=1, fb_thread=T. On fb_valid, outstanding[fb_thread] clears, and:
  - fb_issued=1: pc += INSTR_BYTES, wrapping modulo 2^PC_W.
  - fb_issued=0, fb_miss=0 (hazard stall): pc unchanged; thread stays READY (replay).
  - fb_miss=1: pc unchanged; thread -> WAIT. fb_miss takes priority over fb_issued.
- refill_done: WAIT -> READY for refill_thread. It is ignored if that thread is already READY. The thread is eligible from the following cycle.
- br_taken: pc[br_thread] <= br_target. Thread state is unchanged (a WAITing thread stays WAIT with the new pc).
- Same-cycle collisions on one thread:
  - br_taken beats fb_issued increment: pc = br_target.
  - fb_miss with br_taken: pc = br_target, state = WAIT.
  - refill_done with fb_miss on the same thread: WAIT wins.
- Per-thread throughput:
  - A single READY thread fetches at most every other cycle (it is outstanding in between).
  - With N_THREADS>=2 all READY, fetch_valid=1 every cycle.
- thread_waiting is a direct registered copy of the state bits.
- fb_valid with a fb_thread that is not outstanding is ignored.

Test Plan:
- Reset sequencing: boot_pc=0x1000, all fb_issued=1 -> fetch_thread sequence 0,1,2,3,0, with pcs 0x1000 ×4 then 0x1004 for thread 0 at cycle 5; fetch_valid=0 in the first cycle after reset.
- Hazard replay: thread 1 gets fb_issued=0, fb_miss=0 at pc 0x1000 -> thread 1's next fetch_pc is still 0x1000; other threads continue advancing.
- Miss park/unpark: thread 2 fb_miss=1 -> thread_waiting=4'b0100, thread 2 skipped (sequence 0,1,3,0,1,3); refill_done for thread 2 -> thread 2 refetches the same pc and thread_waiting=0.
- Branch collision: same cycle fb_valid thread 0 fb_issued=1 and br_taken thread 0 target 0x2000 -> thread 0's next fetch_pc=0x2000, not 0x1004.
- Single thread: threads 1-3 in WAIT -> fetch_valid toggles 1,0,1,0 for thread 0; all four WAIT -> fetch_valid=0 steady.
- Mid-operation reset: rst asserted while thread 3 is WAIT and pcs are advanced -> next cycle fetch_valid=0 and thread_waiting=0; following fetch is thread 0 at boot_pc.
